// File: rtl/fp_pkg.sv
// fp_pkg: shared tiny-float constants and types for the add/sub datapath
// and its normalize/pack back end (fnorm_pack).
//   EXP_W   - biased exponent width; exponent 0 encodes zero
//   MAN_W   - significand width including the explicit leading 1
//   FP_W    - packed {sign, exp, man} width
//   EXP_MAX - largest biased exponent
//   LZC_W   - width of a leading-zero count over MAN_W bits (0..MAN_W)
//   FP_ZERO - packed positive zero
package fp_pkg;

    localparam int EXP_W   = 3;
    localparam int MAN_W   = 2;
    localparam int FP_W    = 1 + EXP_W + MAN_W;
    localparam int EXP_MAX = (1 << EXP_W) - 1;
    localparam int LZC_W   = $clog2(MAN_W + 1);

    localparam logic [FP_W-1:0] FP_ZERO = '0;

    // Stage-1 register contents: recovered sign/magnitude plus the shift
    // decision, so stage 2 is a pure mux/adder on registered values.
    typedef struct packed {
        logic             sign;
        logic [MAN_W:0]   mag;
        logic [EXP_W-1:0] exp;
        logic             tag;
        logic             rsh;
        logic             zero;
        logic [LZC_W-1:0] lzc;
    } s1_t;

endpackage

// File: rtl/fnorm_lzc.sv
// fnorm_lzc: combinational leading-zero counter over MAN_W bits.
//   val      in  MAN_W  value to scan (MSB first)
//   count    out LZC_W  number of leading zeros, MAN_W when val is 0
//   all_zero out 1      val == 0
module fnorm_lzc
    import fp_pkg::*;
(
    input  logic [MAN_W-1:0] val,
    output logic [LZC_W-1:0] count,
    output logic             all_zero
);

    always_comb begin
        count    = LZC_W'(MAN_W);
        all_zero = (val == '0);
        // Ascending scan: the highest set bit is the last to write count.
        for (int i = 0; i < MAN_W; i++) begin
            if (val[i]) begin
                count = LZC_W'(MAN_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fnorm_pack.sv
// fnorm_pack: normalize/pack back end of the tiny-float add/sub datapath.
// Two pipeline stages:
//   stage 1 - recover result sign and magnitude, decide the shift
//   stage 2 - normalize, adjust exponent, saturate or flush, pack
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_sum              raw add/sub significand result (MAN_W+1 bits)
//   in_exp              common aligned exponent
//   in_s1, in_s2        operand signs
//   in_tag              sideband bit, passed through
//   out_valid/out_ready output handshake
//   out_fp              packed {sign, exp, man}
//   out_tag             tag aligned with out_fp
//   out_ovf, out_unf    saturated / flushed-to-zero flags
// Build option: define FNORM_RNE_EN to round the right-shift path
// half-to-even instead of truncating the dropped bit.
module fnorm_pack
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W:0]   in_sum,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_s1,
    input  logic             in_s2,
    input  logic             in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_fp,
    output logic             out_tag,
    output logic             out_ovf,
    output logic             out_unf
);

    localparam logic [EXP_W:0] EXP_MAX_W = (EXP_W+1)'(EXP_MAX);

    // Handshake: a beat transfers on any edge where valid && ready.
    // Each stage loads when the stage after it is empty or is being drained
    // this cycle, so ready ripples combinationally back from out_ready and
    // full throughput (accept and emit in the same cycle) is sustained.
    logic s1_valid;
    s1_t  s1_q;
    s1_t  s1_next;
    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    // ---------------- stage 1: sign/magnitude and shift decision ----------
    logic             sub;
    logic [LZC_W-1:0] lz_count;
    logic             lz_all_zero;

    assign sub = in_s1 ^ in_s2;

    fnorm_lzc u_lzc (
        .val      (s1_next.mag[MAN_W-1:0]),
        .count    (lz_count),
        .all_zero (lz_all_zero)
    );

    always_comb begin
        s1_next      = '0;
        s1_next.sign = in_s1;
        s1_next.mag  = in_sum;
        s1_next.exp  = in_exp;
        s1_next.tag  = in_tag;
        // A negative difference wrapped modulo 2^(MAN_W+1); negate it back.
        if (sub && in_sum[MAN_W]) begin
            s1_next.sign = ~in_s1;
            s1_next.mag  = -in_sum;
        end
        s1_next.rsh  = !sub && s1_next.mag[MAN_W];
        s1_next.zero = !s1_next.mag[MAN_W] && lz_all_zero;
        s1_next.lzc  = lz_count;
    end

    // ---------------- stage 2: normalize and pack -------------------------
    logic [FP_W-1:0]  nx_fp;
    logic             nx_ovf;
    logic             nx_unf;
    logic [MAN_W-1:0] man_r;
    logic [EXP_W:0]   exp_up;
    logic [EXP_W:0]   exp_dn;
    logic [MAN_W:0]   man_l;

    always_comb begin
        nx_fp  = FP_ZERO;
        nx_ovf = 1'b0;
        nx_unf = 1'b0;
        man_r  = s1_q.mag[MAN_W:1];
        exp_up = {1'b0, s1_q.exp} + (EXP_W+1)'(1);
`ifdef FNORM_RNE_EN
        // One dropped bit means every round-up case is a tie; round to even.
        if (s1_q.mag[0] && s1_q.mag[1]) begin
            if (&man_r) begin
                man_r  = {1'b1, {(MAN_W-1){1'b0}}};
                exp_up = exp_up + (EXP_W+1)'(1);
            end else begin
                man_r = man_r + MAN_W'(1);
            end
        end
`endif
        exp_dn = {1'b0, s1_q.exp} - (EXP_W+1)'(s1_q.lzc);
        man_l  = s1_q.mag << s1_q.lzc;

        if (s1_q.zero) begin
            nx_fp = FP_ZERO;
        end else if (s1_q.rsh) begin
            if (exp_up > EXP_MAX_W) begin
                nx_fp  = {s1_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
                nx_ovf = 1'b1;
            end else begin
                nx_fp = {s1_q.sign, exp_up[EXP_W-1:0], man_r};
            end
        end else if ({1'b0, s1_q.exp} <= (EXP_W+1)'(s1_q.lzc)) begin
            nx_unf = 1'b1;
        end else begin
            nx_fp = {s1_q.sign, exp_dn[EXP_W-1:0], man_l[MAN_W-1:0]};
        end
    end

    // ---------------- pipeline registers ----------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            out_valid <= 1'b0;
            out_fp    <= FP_ZERO;
            out_tag   <= 1'b0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_fp  <= nx_fp;
                    out_tag <= s1_q.tag;
                    out_ovf <= nx_ovf;
                    out_unf <= nx_unf;
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_fnorm_pack.sv
// tb_fnorm_pack: scoreboard bench for fnorm_pack. Directed vectors from the
// block's test plan, backpressure and mid-flight reset scenarios, then
// randomized beats under random out_ready checked against an arithmetic
// reference model.
module tb_fnorm_pack;
    import fp_pkg::*;

    localparam int SB_W = FP_W + 3;   // {fp, tag, ovf, unf}

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [MAN_W:0]   in_sum;
    logic [EXP_W-1:0] in_exp;
    logic             in_s1;
    logic             in_s2;
    logic             in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [FP_W-1:0]  out_fp;
    logic             out_tag;
    logic             out_ovf;
    logic             out_unf;

    logic [SB_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    fnorm_pack dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_exp    (in_exp),
        .in_s1     (in_s1),
        .in_s2     (in_s2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp    (out_fp),
        .out_tag   (out_tag),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {fp, ovf, unf} computed from signed arithmetic on the inputs.
    function automatic logic [FP_W+1:0] model(input logic s1, input logic s2,
                                              input int sum, input int ex);
        int m, e, man, sh, lo, top, full;
        logic sign, sub;
        top  = 1 << MAN_W;
        full = 1 << (MAN_W + 1);
        sub  = s1 ^ s2;
        sign = s1;
        m    = sum;
        if (sub && sum >= top) begin
            sign = !s1;
            m    = (full - sum) % full;
        end
        if (m == 0) return '0;
        if (!sub && m >= top) begin
            man = m / 2;
            e   = ex + 1;
`ifdef FNORM_RNE_EN
            if ((m % 2) == 1 && (man % 2) == 1) begin
                man = man + 1;
                if (man == top) begin
                    man = top / 2;
                    e   = ex + 2;
                end
            end
`endif
            if (e > EXP_MAX) return {sign, {(EXP_W+MAN_W){1'b1}}, 2'b10};
            return {sign, EXP_W'(e), MAN_W'(man), 2'b00};
        end
        lo = m % top;
        sh = 0;
        while (sh < MAN_W && (lo << sh) < (top / 2)) sh++;
        if (ex <= sh) return {FP_ZERO, 2'b01};
        return {sign, EXP_W'(ex - sh), MAN_W'(m << sh), 2'b00};
    endfunction

    // ---------------- driver ----------------
    // Presents one beat and waits (bounded) until it is accepted; the
    // expected result is pushed on the acceptance edge.
    task automatic send(input logic s1, input logic s2, input logic [MAN_W:0] sum,
                        input logic [EXP_W-1:0] ex, input logic tag,
                        input bit has_want, input logic [FP_W+1:0] want);
        logic rdy;
        logic [FP_W+1:0] w;
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_s1    = s1;
        in_s2    = s2;
        in_sum   = sum;
        in_exp   = ex;
        in_tag   = tag;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && guard < 200);
        if (!rdy) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", guard);
        end else begin
            w = has_want ? want : model(s1, s2, int'(sum), int'(ex));
            exp_q.push_back({w[FP_W+1:2], tag, w[1:0]});
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_out: got %h with empty queue",
                         {out_fp, out_tag, out_ovf, out_unf});
            end else begin
                check("out_beat", 32'({out_fp, out_tag, out_ovf, out_unf}),
                      32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rand_done;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_exp    = '0;
        in_s1     = 1'b0;
        in_s2     = 1'b0;
        in_tag    = 1'b0;
        out_ready = 1'b0;
        rand_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_fp",    32'(out_fp),    32'd0);
        check("rst_flags",     32'({out_tag, out_ovf, out_unf}), 32'd0);
        @(posedge clk);
        #1;

        // Latency: add carry, out_valid exactly two cycles after accept
        out_ready = 1'b1;
`ifdef FNORM_RNE_EN
        send(1'b0, 1'b0, 3'b111, 3'd3, 1'b0, 1'b1, {6'b0_101_10, 2'b00});
`else
        send(1'b0, 1'b0, 3'b111, 3'd3, 1'b0, 1'b1, {6'b0_100_11, 2'b00});
`endif
        idle();
        @(negedge clk);
        check("latency_c1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_c2", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        // Directed plan vectors, back to back
        send(1'b0, 1'b0, 3'b110, 3'd3, 1'b1, 1'b1, {6'b0_100_11, 2'b00});
        send(1'b0, 1'b1, 3'b111, 3'd3, 1'b0, 1'b1, {6'b1_010_10, 2'b00});
        send(1'b1, 1'b0, 3'b000, 3'd5, 1'b1, 1'b1, {6'b0_000_00, 2'b00});
        send(1'b0, 1'b0, 3'b100, 3'd7, 1'b0, 1'b1, {6'b0_111_11, 2'b10});
        send(1'b0, 1'b1, 3'b001, 3'd1, 1'b1, 1'b1, {6'b0_000_00, 2'b01});
        idle();
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: two beats fill the pipe, then in_ready drops
        out_ready = 1'b0;
        send(1'b0, 1'b0, 3'b101, 3'd2, 1'b0, 1'b0, '0);
        send(1'b1, 1'b1, 3'b011, 3'd4, 1'b1, 1'b0, '0);
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        fork
            begin
                send(1'b0, 1'b1, 3'b110, 3'd6, 1'b0, 1'b0, '0);
                send(1'b1, 1'b0, 3'b010, 3'd3, 1'b1, 1'b0, '0);
                idle();
            end
            begin
                out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("bp_one_per_cycle", 32'(out_valid), 32'd1);
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-flight: both in-flight beats must vanish
        out_ready = 1'b0;
        send(1'b0, 1'b0, 3'b100, 3'd7, 1'b1, 1'b0, '0);
        send(1'b0, 1'b0, 3'b110, 3'd2, 1'b1, 1'b0, '0);
        idle();
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready",  32'(in_ready),  32'd1);
        check("mrst_out_fp",    32'(out_fp),    32'd0);
        check("mrst_flags",     32'({out_tag, out_ovf, out_unf}), 32'd0);
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // Randomized beats under random backpressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), 1'b0, '0);
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                end
                idle();
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join

        // Drain
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
